h14rx_pkt_avi_info_frame_parser: RTL and testbench
==================================================

Name: h14rx_pkt_avi_info_frame_parser

Overview:
Receive-side counterpart of the AVI InfoFrame packet generator (HDMI 1.4 Section 8.2.1). It consumes a byte-serial InfoFrame data-island packet: HB0..HB2, then PB0..PB27 (31 bytes).
- Validates header and checksum, extracts all AVI fields into registers, and reports status.
- Sits after the data-island BCH/ECC stage in the sink path and feeds video-format configuration logic.

Parameters:
- ExpectVersion, 8'd2, HB1 value required for acceptance.
- HoldOnError, 1'b1, 1: field registers are not updated when a checksum error occurs; 0: they update anyway.

Ports:
- clk  in  1  Core clock.
- rst_n  in  1  Synchronous active-low reset.
- in_valid  in  1  Byte valid.
- in_ready  out  1  Byte accepted when in_valid && in_ready.
- in_first  in  1  Marks HB0 of a packet; qualified by in_valid.
- in_data  in  8  Packet byte.
- avi_valid  out  1  One-cycle pulse: a packet was parsed and its fields were updated.
- pkt_ignored  out  1  One-cycle pulse: header is not an AVI header; packet skipped.
- err_checksum  out  1  Sticky until next avi_valid; last AVI packet failed checksum.
- err_truncated  out  1  One-cycle pulse: in_first arrived mid-packet.
- err_reserved  out  1  See Optional Feature.
- video_format  out  2  PB1[6:5].
- afi_present  out  1  PB1[4].
- bar_info  out  2  PB1[3:2].
- scan_info  out  2  PB1[1:0].
- colorimetry  out  2  PB2[7:6].
- picture_ar  out  2  PB2[5:4].
- active_ar  out  4  PB2[3:0].
- it_content  out  1  PB3[7].
- ext_colorimetry  out  3  PB3[6:4].
- rgb_quant  out  2  PB3[3:2].
- nups  out  2  PB3[1:0].
- vic  out  7  PB4[6:0].
- ycc_quant  out  2  PB5[7:6].
- content_type  out  2  PB5[5:4].
- pixel_rep  out  4  PB5[3:0].
- top_bar_end  out  16  {PB7,PB6}.
- bot_bar_start  out  16  {PB9,PB8}.
- left_bar_end  out  16  {PB11,PB10}.
- right_bar_start  out  16  {PB13,PB12}.

Behaviour:
- Reset: all outputs 0, except active_ar = 4'b1000 and in_ready = 1. FSM in IDLE, byte counter 0, checksum accumulator 0.
- FSM states:
  - IDLE: bytes without in_first are dropped. in_first moves to HEADER and loads sum = HB0.
  - HEADER: captures HB1 and HB2. After HB2, the header check is HB0 == 8'h82, HB1 == ExpectVersion, HB2[4:0] == 5'd13. Pass -> BODY; fail -> SKIP.
  - BODY: counts PB0..PB27. sum += byte for PB0..PB13 only (8-bit wraparound). PB1..PB13 go to shadow registers. After the PB27 handshake -> REPORT.
  - SKIP: drops bytes until 28 PB bytes have been counted, then -> IDLE and pulses pkt_ignored on the following cycle.
  - REPORT: lasts exactly one cycle with in_ready = 0.
    - checksum ok (sum == 8'h00): copy shadow to outputs, pulse avi_valid, clear err_checksum.
    - checksum bad: set err_checksum; copy shadow and pulse avi_valid only if HoldOnError == 0.
    - Then -> IDLE.
- Latency: outputs and the avi_valid pulse appear on the cycle after the PB27 handshake.
- in_ready is 1 in all states except REPORT.
- Outputs are stable between updates. Shadow registers never reach outputs mid-packet.
- in_first in HEADER, BODY or SKIP: abandon the current packet and pulse err_truncated next cycle. That byte is treated as HB0 of a new packet (-> HEADER, sum reloaded). No avi_valid for the abandoned packet.
- in_first during REPORT is not accepted (in_ready = 0); the source holds it.
- in_valid deasserted mid-packet: the FSM waits indefinitely; counter and sum hold.
- Reset asserted mid-packet: return to reset state next cycle; a partial packet never updates outputs.

Optional Feature:
- Macro H14RX_AVI_RESERVED_CHECK_EN.
- Defined: in BODY, any nonzero bit in PB1[7], PB4[7] or PB14..PB27 sets a flag. In REPORT, err_reserved = flag (registered, held until next REPORT). The fields still update per checksum rules.
- Undefined: no reserved-bit logic is built and err_reserved is tied to 0.

Test Plan:
- Default frame 82 02 0D, PB0=63, PB2=08, PB4=04, rest 00 -> avi_valid one cycle after PB27; vic=4, active_ar=8, err_checksum=0.
- Same frame with PB0=64 -> err_checksum=1. HoldOnError=1: no avi_valid, fields keep prior values. HoldOnError=0: avi_valid pulses.
- Bar frame: PB1=0C, PB6..PB13 = FF FF 00 00 FF FF 00 00, PB0 recomputed -> top_bar_end=FFFF, bot_bar_start=0000, left_bar_end=FFFF, bar_info=3.
- Header 84 01 0A (audio InfoFrame) followed by 28 bytes -> pkt_ignored pulses once, no avi_valid, outputs unchanged.
- in_first reasserted at PB10, then a valid full frame -> err_truncated pulse, then one avi_valid carrying the second frame's values.
- Macro defined, PB20=01 with checksum valid -> avi_valid=1, err_reserved=1. Macro undefined -> err_reserved=0.

Source files
------------

// File: rtl/h14rx_pkt_avi_info_frame_parser.sv
// h14rx_pkt_avi_info_frame_parser: byte-serial AVI InfoFrame receiver with header/checksum validation.
// Define H14RX_AVI_RESERVED_CHECK_EN to build the reserved-bit checker behind err_reserved.
module h14rx_pkt_avi_info_frame_parser #(
    parameter logic [7:0] ExpectVersion = 8'd2,
    parameter bit         HoldOnError   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_first,
    input  logic [7:0]  in_data,
    output logic        avi_valid,
    output logic        pkt_ignored,
    output logic        err_checksum,
    output logic        err_truncated,
    output logic        err_reserved,
    output logic [1:0]  video_format,
    output logic        afi_present,
    output logic [1:0]  bar_info,
    output logic [1:0]  scan_info,
    output logic [1:0]  colorimetry,
    output logic [1:0]  picture_ar,
    output logic [3:0]  active_ar,
    output logic        it_content,
    output logic [2:0]  ext_colorimetry,
    output logic [1:0]  rgb_quant,
    output logic [1:0]  nups,
    output logic [6:0]  vic,
    output logic [1:0]  ycc_quant,
    output logic [1:0]  content_type,
    output logic [3:0]  pixel_rep,
    output logic [15:0] top_bar_end,
    output logic [15:0] bot_bar_start,
    output logic [15:0] left_bar_end,
    output logic [15:0] right_bar_start
);
    typedef enum logic [2:0] {IDLE, HEADER, BODY, SKIP, REPORT} state_t;

    state_t       state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [7:0]   sum_q, sum_d, hb0_q, hb0_d, hb1_q, hb1_d;
    logic [101:0] sh_q, sh_d, fld_q, fld_d;
    logic         in_ready_q, in_ready_d, avi_valid_q, avi_valid_d;
    logic         pkt_ignored_q, pkt_ignored_d, err_checksum_q, err_checksum_d;
    logic         err_truncated_q, err_truncated_d;
    logic         acc, narrow, in_sum, in_shadow, hdr_ok, ck_ok, take;

    // PB1 and PB4 carry a reserved bit 7, so only 7 bits of them are shifted into the shadow
    assign acc       = in_valid && in_ready_q;
    assign narrow    = cnt_q == 5'd1 || cnt_q == 5'd4;
    assign in_sum    = cnt_q <= 5'd13;
    assign in_shadow = cnt_q != 5'd0 && in_sum;
    assign hdr_ok    = hb0_q == 8'h82 && hb1_q == ExpectVersion && in_data[4:0] == 5'd13;
    assign ck_ok     = sum_q == 8'h00;
    assign take      = ck_ok || !HoldOnError;

`ifdef H14RX_AVI_RESERVED_CHECK_EN
    logic rsv_q, rsv_d, rsv_hit, err_reserved_q, err_reserved_d;
    assign rsv_hit      = narrow ? in_data[7] : (cnt_q >= 5'd14 && in_data != 8'h00);
    assign err_reserved = err_reserved_q;
`else
    assign err_reserved = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        sum_d           = sum_q;
        hb0_d           = hb0_q;
        hb1_d           = hb1_q;
        sh_d            = sh_q;
        fld_d           = fld_q;
        err_checksum_d  = err_checksum_q;
        avi_valid_d     = 1'b0;
        pkt_ignored_d   = 1'b0;
        err_truncated_d = 1'b0;
`ifdef H14RX_AVI_RESERVED_CHECK_EN
        rsv_d           = rsv_q;
        err_reserved_d  = err_reserved_q;
`endif
        if (state_q == REPORT) begin
            state_d = IDLE;
        end else if (acc && in_first) begin
            state_d         = HEADER;
            cnt_d           = 5'd0;
            sum_d           = in_data;
            hb0_d           = in_data;
            err_truncated_d = state_q != IDLE;
`ifdef H14RX_AVI_RESERVED_CHECK_EN
            rsv_d           = 1'b0;
`endif
        end else if (acc && state_q == HEADER) begin
            sum_d   = sum_q + in_data;
            hb1_d   = cnt_q == 5'd0 ? in_data : hb1_q;
            cnt_d   = cnt_q == 5'd0 ? 5'd1 : 5'd0;
            state_d = cnt_q == 5'd0 ? HEADER : (hdr_ok ? BODY : SKIP);
        end else if (acc && state_q == BODY) begin
            sum_d = in_sum ? sum_q + in_data : sum_q;
            sh_d  = !in_shadow ? sh_q : narrow ? {in_data[6:0], sh_q[101:7]} : {in_data, sh_q[101:8]};
            cnt_d = cnt_q + 5'd1;
`ifdef H14RX_AVI_RESERVED_CHECK_EN
            rsv_d = rsv_q | rsv_hit;
`endif
            if (cnt_q == 5'd27) begin
                state_d        = REPORT;
                err_checksum_d = !ck_ok;
                avi_valid_d    = take;
                fld_d          = take ? sh_q : fld_q;
`ifdef H14RX_AVI_RESERVED_CHECK_EN
                err_reserved_d = rsv_q | rsv_hit;
`endif
            end
        end else if (acc && state_q == SKIP) begin
            cnt_d         = cnt_q + 5'd1;
            state_d       = cnt_q == 5'd27 ? IDLE : SKIP;
            pkt_ignored_d = cnt_q == 5'd27;
        end
        in_ready_d = state_d != REPORT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= 5'd0;
            sum_q           <= 8'h00;
            hb0_q           <= 8'h00;
            hb1_q           <= 8'h00;
            sh_q            <= '0;
            fld_q           <= {91'd0, 4'b1000, 7'd0};
            in_ready_q      <= 1'b1;
            avi_valid_q     <= 1'b0;
            pkt_ignored_q   <= 1'b0;
            err_checksum_q  <= 1'b0;
            err_truncated_q <= 1'b0;
`ifdef H14RX_AVI_RESERVED_CHECK_EN
            rsv_q           <= 1'b0;
            err_reserved_q  <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            sum_q           <= sum_d;
            hb0_q           <= hb0_d;
            hb1_q           <= hb1_d;
            sh_q            <= sh_d;
            fld_q           <= fld_d;
            in_ready_q      <= in_ready_d;
            avi_valid_q     <= avi_valid_d;
            pkt_ignored_q   <= pkt_ignored_d;
            err_checksum_q  <= err_checksum_d;
            err_truncated_q <= err_truncated_d;
`ifdef H14RX_AVI_RESERVED_CHECK_EN
            rsv_q           <= rsv_d;
            err_reserved_q  <= err_reserved_d;
`endif
        end
    end

    assign in_ready      = in_ready_q;
    assign avi_valid     = avi_valid_q;
    assign pkt_ignored   = pkt_ignored_q;
    assign err_checksum  = err_checksum_q;
    assign err_truncated = err_truncated_q;
    // Field register layout, MSB first: PB13..PB5, PB4[6:0], PB3, PB2, PB1[6:0]
    assign {right_bar_start, left_bar_end, bot_bar_start, top_bar_end,
            ycc_quant, content_type, pixel_rep, vic,
            it_content, ext_colorimetry, rgb_quant, nups,
            colorimetry, picture_ar, active_ar,
            video_format, afi_present, bar_info, scan_info} = fld_q;
endmodule

// File: tb/tb_h14rx_pkt_avi_info_frame_parser.sv
// tb_h14rx_pkt_avi_info_frame_parser: random packet stream into two parser instances
// (HoldOnError 1 and 0), checked every cycle against a packet-level reference model.
module tb_h14rx_pkt_avi_info_frame_parser;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_first = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic        rdy [2], avi [2], ign [2], eck [2], trn [2], ers [2];
    logic [1:0]  vf [2], bar [2], scan [2], col [2], par [2], rgbq [2], nupsw [2], yccq [2], ctyp [2];
    logic        afi [2], itc [2];
    logic [3:0]  aar [2], prep [2];
    logic [2:0]  ext [2];
    logic [6:0]  vicw [2];
    logic [15:0] top [2], bot [2], lft [2], rgt [2];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        h14rx_pkt_avi_info_frame_parser #(.ExpectVersion(8'd2), .HoldOnError(g == 0)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[g]),
            .in_first(in_first), .in_data(in_data), .avi_valid(avi[g]),
            .pkt_ignored(ign[g]), .err_checksum(eck[g]), .err_truncated(trn[g]),
            .err_reserved(ers[g]), .video_format(vf[g]), .afi_present(afi[g]),
            .bar_info(bar[g]), .scan_info(scan[g]), .colorimetry(col[g]),
            .picture_ar(par[g]), .active_ar(aar[g]), .it_content(itc[g]),
            .ext_colorimetry(ext[g]), .rgb_quant(rgbq[g]), .nups(nupsw[g]),
            .vic(vicw[g]), .ycc_quant(yccq[g]), .content_type(ctyp[g]),
            .pixel_rep(prep[g]), .top_bar_end(top[g]), .bot_bar_start(bot[g]),
            .left_bar_end(lft[g]), .right_bar_start(rgt[g])
        );
    end

    task automatic chk(input string n, input int h, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s dut%0d got=%0h want=%0h t=%0t", n, h, a, e, $time);
        end
    endtask

    // Reference model: collects each packet's bytes and judges it once all 31 have arrived
    logic       m_ok = 1'b0, m_rdy = 1'b1, m_act = 1'b0, m_nr;
    logic       m_ign = 1'b0, m_trunc = 1'b0, m_ck = 1'b0, m_rsv = 1'b0, m_r;
    logic       m_avi [2];
    logic [7:0] m_pb [2][1:13];
    logic [7:0] cur [$];
    int         m_s;

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_ok = 1'b1; m_rdy = 1'b1; m_act = 1'b0; cur.delete();
            m_ign = 1'b0; m_trunc = 1'b0; m_ck = 1'b0; m_rsv = 1'b0;
            for (int h = 0; h < 2; h++) begin
                m_avi[h] = 1'b0;
                for (int k = 1; k <= 13; k++) m_pb[h][k] = (k == 2) ? 8'h08 : 8'h00;
            end
        end else begin
            m_nr = 1'b1; m_ign = 1'b0; m_trunc = 1'b0; m_avi[0] = 1'b0; m_avi[1] = 1'b0;
            if (in_valid && m_rdy) begin
                if (in_first) begin
                    m_trunc = m_act; cur.delete(); cur.push_back(in_data); m_act = 1'b1;
                end else if (m_act) begin
                    cur.push_back(in_data);
                    if (cur.size() == 31) begin
                        m_act = 1'b0;
                        if (cur[0] == 8'h82 && cur[1] == 8'd2 && cur[2][4:0] == 5'd13) begin
                            m_s = 0;
                            for (int k = 0; k <= 16; k++) m_s += int'(cur[k]);
                            m_r = cur[4][7] | cur[7][7];
                            for (int k = 17; k <= 30; k++) m_r = m_r | (cur[k] != 8'h00);
`ifdef H14RX_AVI_RESERVED_CHECK_EN
                            m_rsv = m_r;
`else
                            m_rsv = 1'b0;
`endif
                            m_ck = (m_s % 256) != 0;
                            for (int h = 0; h < 2; h++)
                                if (!m_ck || h == 1) begin
                                    m_avi[h] = 1'b1;
                                    for (int k = 1; k <= 13; k++) m_pb[h][k] = cur[3 + k];
                                end
                            m_nr = 1'b0;
                        end else begin
                            m_ign = 1'b1;
                        end
                    end
                end
            end
            m_rdy = m_nr;
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_ok)
            for (int h = 0; h < 2; h++) begin
                chk("in_ready", h, 32'(rdy[h]), 32'(m_rdy));
                chk("avi_valid", h, 32'(avi[h]), 32'(m_avi[h]));
                chk("pkt_ignored", h, 32'(ign[h]), 32'(m_ign));
                chk("err_truncated", h, 32'(trn[h]), 32'(m_trunc));
                chk("err_checksum", h, 32'(eck[h]), 32'(m_ck));
                chk("err_reserved", h, 32'(ers[h]), 32'(m_rsv));
                chk("video_format", h, 32'(vf[h]), 32'(m_pb[h][1][6:5]));
                chk("afi_present", h, 32'(afi[h]), 32'(m_pb[h][1][4]));
                chk("bar_info", h, 32'(bar[h]), 32'(m_pb[h][1][3:2]));
                chk("scan_info", h, 32'(scan[h]), 32'(m_pb[h][1][1:0]));
                chk("colorimetry", h, 32'(col[h]), 32'(m_pb[h][2][7:6]));
                chk("picture_ar", h, 32'(par[h]), 32'(m_pb[h][2][5:4]));
                chk("active_ar", h, 32'(aar[h]), 32'(m_pb[h][2][3:0]));
                chk("it_content", h, 32'(itc[h]), 32'(m_pb[h][3][7]));
                chk("ext_colorimetry", h, 32'(ext[h]), 32'(m_pb[h][3][6:4]));
                chk("rgb_quant", h, 32'(rgbq[h]), 32'(m_pb[h][3][3:2]));
                chk("nups", h, 32'(nupsw[h]), 32'(m_pb[h][3][1:0]));
                chk("vic", h, 32'(vicw[h]), 32'(m_pb[h][4][6:0]));
                chk("ycc_quant", h, 32'(yccq[h]), 32'(m_pb[h][5][7:6]));
                chk("content_type", h, 32'(ctyp[h]), 32'(m_pb[h][5][5:4]));
                chk("pixel_rep", h, 32'(prep[h]), 32'(m_pb[h][5][3:0]));
                chk("top_bar_end", h, 32'(top[h]), 32'({m_pb[h][7], m_pb[h][6]}));
                chk("bot_bar_start", h, 32'(bot[h]), 32'({m_pb[h][9], m_pb[h][8]}));
                chk("left_bar_end", h, 32'(lft[h]), 32'({m_pb[h][11], m_pb[h][10]}));
                chk("right_bar_start", h, 32'(rgt[h]), 32'({m_pb[h][13], m_pb[h][12]}));
            end
    end

    logic [7:0] pk [31];

    task automatic put(input logic f, input logic [7:0] d);
        int n;
        logic acc;
        if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0; in_first = 1'($urandom); in_data = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1; in_first = f; in_data = d; n = 0;
        do begin
            @(negedge clk); acc = rdy[0];
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            total++; bad++;
            $display("FAIL handshake_timeout got=in_ready_low want=accept t=%0t", $time);
        end
        in_valid = 1'b0; in_first = 1'b0;
    endtask

    task automatic send(input int n, input int et);
        for (int i = 0; i < n; i++) begin
            put(i == 0, pk[i]);
            if (i == 0 && et != 2) chk("trunc_lit", 0, 32'(trn[0]), 32'(et));
        end
    endtask

    task automatic fix();
        int s;
        s = 0;
        for (int k = 0; k <= 16; k++) if (k != 3) s += int'(pk[k]);
        pk[3] = 8'(256 - s % 256);
    endtask

    task automatic mk_def();
        for (int k = 0; k < 31; k++) pk[k] = 8'h00;
        pk[0] = 8'h82; pk[1] = 8'h02; pk[2] = 8'h0D; pk[3] = 8'h63; pk[5] = 8'h08; pk[7] = 8'h04;
    endtask

    task automatic mk_rand();
        mk_def();
        pk[2] = {3'($urandom), 5'd13};
        for (int k = 4; k <= 16; k++) pk[k] = 8'($urandom);
        if ($urandom_range(0, 3) == 0) pk[$urandom_range(17, 30)] = 8'($urandom);
        fix();
    endtask

    task automatic do_reset();
        in_valid = 1'($urandom); in_first = 1'($urandom); in_data = 8'($urandom); rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0; in_first = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_active_ar", 0, 32'(aar[0]), 32'd8);
        chk("rst_in_ready", 0, 32'(rdy[0]), 32'd1);
        chk("rst_vic", 0, 32'(vicw[0]), 32'd0);

        mk_def(); send(31, 0);
        chk("def_avi", 0, 32'(avi[0]), 32'd1);
        chk("def_vic", 0, 32'(vicw[0]), 32'd4);
        chk("def_aar", 0, 32'(aar[0]), 32'd8);
        chk("def_ck", 0, 32'(eck[0]), 32'd0);
        chk("def_report_ready", 0, 32'(rdy[0]), 32'd0);

        mk_def(); pk[3] = 8'h64; pk[7] = 8'h05; send(31, 0);
        chk("bad_avi_hold", 0, 32'(avi[0]), 32'd0);
        chk("bad_vic_hold", 0, 32'(vicw[0]), 32'd4);
        chk("bad_ck_hold", 0, 32'(eck[0]), 32'd1);
        chk("bad_avi_pass", 1, 32'(avi[1]), 32'd1);
        chk("bad_vic_pass", 1, 32'(vicw[1]), 32'd5);
        chk("bad_ck_pass", 1, 32'(eck[1]), 32'd1);

        mk_def(); pk[4] = 8'h0C; pk[7] = 8'h00;
        pk[9] = 8'hFF; pk[10] = 8'hFF; pk[13] = 8'hFF; pk[14] = 8'hFF; fix(); send(31, 0);
        chk("bar_top", 0, 32'(top[0]), 32'hFFFF);
        chk("bar_bot", 0, 32'(bot[0]), 32'h0000);
        chk("bar_left", 0, 32'(lft[0]), 32'hFFFF);
        chk("bar_info", 0, 32'(bar[0]), 32'd3);
        chk("bar_ck_clear", 0, 32'(eck[0]), 32'd0);

        for (int k = 0; k < 31; k++) pk[k] = 8'($urandom);
        pk[0] = 8'h84; pk[1] = 8'h01; pk[2] = 8'h0A; send(31, 0);
        chk("aud_ignored", 0, 32'(ign[0]), 32'd1);
        chk("aud_avi", 0, 32'(avi[0]), 32'd0);
        chk("aud_top_kept", 0, 32'(top[0]), 32'hFFFF);

        mk_def(); send(13, 0);
        mk_def(); pk[7] = 8'h10; fix(); send(31, 1);
        chk("trunc_avi", 0, 32'(avi[0]), 32'd1);
        chk("trunc_vic", 0, 32'(vicw[0]), 32'd16);

        mk_def(); pk[23] = 8'h01; send(31, 0);
        chk("rsv_avi", 0, 32'(avi[0]), 32'd1);
`ifdef H14RX_AVI_RESERVED_CHECK_EN
        chk("rsv_lit", 0, 32'(ers[0]), 32'd1);
`else
        chk("rsv_lit", 0, 32'(ers[0]), 32'd0);
`endif

        mk_def(); pk[7] = 8'h22; fix(); send(10, 0);
        do_reset();
        chk("midrst_vic", 0, 32'(vicw[0]), 32'd0);
        chk("midrst_aar", 0, 32'(aar[0]), 32'd8);
        for (int i = 10; i < 31; i++) put(1'b0, pk[i]);
        chk("midrst_no_avi", 0, 32'(avi[0]), 32'd0);
        chk("midrst_vic_kept", 0, 32'(vicw[0]), 32'd0);

        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin
                    mk_rand();
                    if ($urandom_range(0, 4) == 0) pk[3] = pk[3] + 8'd1 + 8'($urandom_range(0, 254));
                    send(31, 2);
                end
                5, 6: begin
                    mk_rand();
                    pk[$urandom_range(0, 2)] ^= 8'(1 << $urandom_range(0, 7));
                    send(31, 2);
                end
                7: begin
                    mk_rand();
                    send(int'($urandom_range(1, 30)), 2);
                end
                8: repeat ($urandom_range(1, 3)) put(1'b0, 8'($urandom));
                default: do_reset();
            endcase
        end
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end
endmodule
